// File: rtl/rom_player_pkg.sv
// Shared encodings for the ROM playback sequencer: playback modes and FSM states.
package rom_player_pkg;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_LOOP     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_UP   = 2'd1;
  localparam state_t ST_DOWN = 2'd2;

endpackage

// File: rtl/rom_sync.sv
// Registered-read ROM. The array itself is never reset; only the output word is.
module rom_sync #(
  parameter int    DW       = 8,
  parameter int    AW       = 8,
  parameter string HEX_FILE = "ROM.hex"
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     dout <= '0;
    else if (re) dout <= mem[addr];
  end

endmodule

// File: rtl/rom_player.sv
// ROM with a playback sequencer: walks base..end at a programmable sample rate
// in one-shot, loop or ping-pong order and flags each new sample with data_valid.
module rom_player
  import rom_player_pkg::*;
#(
  parameter int    DATA_WIDTH     = 8,
  parameter int    ADDRESS_WIDTH  = 8,
  parameter string HEX_FILE       = "ROM.hex",
  parameter int    PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      start,
  input  logic                      stop,
  input  logic [1:0]                mode,
  input  logic [ADDRESS_WIDTH-1:0]  base_addr,
  input  logic [ADDRESS_WIDTH-1:0]  end_addr,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [ADDRESS_WIDTH-1:0]  address,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      data_valid,
  output logic                      busy,
  output logic                      done,
  output state_t                    dbg_state
);

  localparam logic [ADDRESS_WIDTH-1:0]  A_ONE = ADDRESS_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] P_ONE = PRESCALE_WIDTH'(1);

  state_t                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic [ADDRESS_WIDTH-1:0]  base_q, base_d;
  logic [ADDRESS_WIDTH-1:0]  end_q, end_d;
  logic [PRESCALE_WIDTH-1:0] pcfg_q, pcfg_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic                      issue_q, issue_d;
  logic                      done_q, done_d;
  logic                      valid_q;
  logic                      stop_take, start_take, rd_en;

  // issue_q marks "address just changed, its read is pending"; the read itself
  // happens on the next enabled cycle, giving the registered-ROM latency.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    base_d     = base_q;
    end_d      = end_q;
    pcfg_d     = pcfg_q;
    presc_d    = presc_q;
    addr_d     = addr_q;
    issue_d    = issue_q;
    done_d     = 1'b0;
    stop_take  = ce & stop;
    start_take = ce & start & ~stop;
    rd_en      = ce & issue_q & ~stop_take;
    if (ce) issue_d = 1'b0;

    if (stop_take) begin
      state_d = ST_IDLE;
    end else if (start_take) begin
      mode_d  = mode;
      base_d  = base_addr;
      end_d   = end_addr;
      pcfg_d  = prescale;
      presc_d = prescale;
      addr_d  = base_addr;
      state_d = ST_UP;
      issue_d = 1'b1;
    end else if (ce && state_q != ST_IDLE) begin
      if (presc_q != '0) begin
        presc_d = presc_q - P_ONE;
      end else begin
        presc_d = pcfg_q;
        issue_d = 1'b1;
        if (state_q == ST_UP) begin
          if (addr_q == end_q) begin
            if (mode_q == MODE_PINGPONG && base_q != end_q) begin
              state_d = ST_DOWN;
              addr_d  = end_q - A_ONE;
            end else if (mode_q == MODE_LOOP || mode_q == MODE_PINGPONG) begin
              addr_d = base_q;
            end else begin
              state_d = ST_IDLE;
              issue_d = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            addr_d = addr_q + A_ONE;
          end
        end else if (state_q == ST_DOWN) begin
          if (addr_q == base_q) begin
            state_d = ST_UP;
            addr_d  = base_q + A_ONE;
          end else begin
            addr_d = addr_q - A_ONE;
          end
        end else begin
          state_d = ST_IDLE;
          issue_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ONESHOT;
      base_q  <= '0;
      end_q   <= '0;
      pcfg_q  <= '0;
      presc_q <= '0;
      addr_q  <= '0;
      issue_q <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      end_q   <= end_d;
      pcfg_q  <= pcfg_d;
      presc_q <= presc_d;
      addr_q  <= addr_d;
      issue_q <= issue_d;
      done_q  <= done_d;
      valid_q <= rd_en;
    end
  end

  rom_sync #(
    .DW       (DATA_WIDTH),
    .AW       (ADDRESS_WIDTH),
    .HEX_FILE (HEX_FILE)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .re   (rd_en),
    .addr (addr_q),
    .dout (data)
  );

  assign address    = addr_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule
